// File: rtl/udma_filter_rx_cmd_seq.sv
// rtl/udma_filter_rx_cmd_seq.sv - output-job descriptor queue and sequencer for the filter RX data-out engine

module udma_filter_rx_cmd_fifo #(
  parameter int DW          = 8,
  parameter int QUEUE_DEPTH = 2,
  parameter int PW          = $clog2(QUEUE_DEPTH),
  parameter int CW          = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          resetn_i,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] pop_data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [DW-1:0] mem [QUEUE_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  assign full_o     = (count == CW'(QUEUE_DEPTH));
  assign empty_o    = (count == '0);
  assign pop_data_o = mem[rd_ptr];
  assign count_o    = count;

  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr] <= push_data_i;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + PW'(1);
      if (pop_i)  rd_ptr <= rd_ptr + PW'(1);
      if (push_i && !pop_i)      count <= count + CW'(1);
      else if (!push_i && pop_i) count <= count - CW'(1);
    end
  end

endmodule

module udma_filter_rx_cmd_seq #(
  parameter int L2_AWIDTH_NOAL = 15,
  parameter int TRANS_SIZE     = 16,
  parameter int QUEUE_DEPTH    = 2
) (
  input  logic                               clk_i,
  input  logic                               resetn_i,
  input  logic                               cfg_push_valid_i,
  output logic                               cfg_push_ready_o,
  input  logic [L2_AWIDTH_NOAL-1:0]          cfg_start_addr_i,
  input  logic [1:0]                         cfg_datasize_i,
  input  logic [1:0]                         cfg_mode_i,
  input  logic [TRANS_SIZE-1:0]              cfg_len0_i,
  input  logic [TRANS_SIZE-1:0]              cfg_len1_i,
  input  logic [TRANS_SIZE-1:0]              cfg_len2_i,
  input  logic                               cfg_clr_i,
  output logic                               cmd_start_o,
  input  logic                               cmd_done_i,
  output logic [L2_AWIDTH_NOAL-1:0]          out_start_addr_o,
  output logic [1:0]                         out_datasize_o,
  output logic [1:0]                         out_mode_o,
  output logic [TRANS_SIZE-1:0]              out_len0_o,
  output logic [TRANS_SIZE-1:0]              out_len1_o,
  output logic [TRANS_SIZE-1:0]              out_len2_o,
  output logic                               busy_o,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   pending_o,
  output logic                               evt_done_o,
  output logic                               evt_err_o
);

  localparam int DW = L2_AWIDTH_NOAL + 4 + 3 * TRANS_SIZE;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT
  } state_t;

  state_t state;

  logic                      full;
  logic                      empty;
  logic                      push_hs;
  logic                      push_en;
  logic                      pop_en;
  logic [DW-1:0]             head;
  logic [L2_AWIDTH_NOAL-1:0] head_addr;
  logic [1:0]                head_ds;
  logic [1:0]                head_mode;
  logic [TRANS_SIZE-1:0]     head_len0;
  logic [TRANS_SIZE-1:0]     head_len1;
  logic [TRANS_SIZE-1:0]     head_len2;

  assign cfg_push_ready_o = !full && !cfg_clr_i;
  assign push_hs          = cfg_push_valid_i && cfg_push_ready_o;
  // 2D descriptors are acknowledged but never enqueued; they only raise an error event.
  assign push_en          = push_hs && (cfg_mode_i != 2'd3);
  assign pop_en           = !empty && !cfg_clr_i &&
                            ((state == ST_IDLE) || ((state == ST_WAIT) && cmd_done_i));

  assign {head_addr, head_ds, head_mode, head_len0, head_len1, head_len2} = head;

  udma_filter_rx_cmd_fifo #(
    .DW          (DW),
    .QUEUE_DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .resetn_i    (resetn_i),
    .clr_i       (cfg_clr_i),
    .push_i      (push_en),
    .push_data_i ({cfg_start_addr_i, cfg_datasize_i, cfg_mode_i,
                   cfg_len0_i, cfg_len1_i, cfg_len2_i}),
    .pop_i       (pop_en),
    .pop_data_o  (head),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (pending_o)
  );

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state            <= ST_IDLE;
      cmd_start_o      <= 1'b0;
      busy_o           <= 1'b0;
      evt_done_o       <= 1'b0;
      evt_err_o        <= 1'b0;
      out_start_addr_o <= '0;
      out_datasize_o   <= '0;
      out_mode_o       <= '0;
      out_len0_o       <= '0;
      out_len1_o       <= '0;
      out_len2_o       <= '0;
    end else begin
      cmd_start_o <= 1'b0;
      evt_done_o  <= (state == ST_WAIT) && cmd_done_i;
      evt_err_o   <= push_hs && (cfg_mode_i == 2'd3);

      case (state)
        ST_IDLE: begin
          if (pop_en) begin
            state       <= ST_START;
            cmd_start_o <= 1'b1;
            busy_o      <= 1'b1;
          end
        end
        ST_START: begin
          state  <= ST_WAIT;
          busy_o <= 1'b1;
        end
        ST_WAIT: begin
          if (cmd_done_i) begin
            if (pop_en) begin
              state       <= ST_START;
              cmd_start_o <= 1'b1;
              busy_o      <= 1'b1;
            end else begin
              state  <= ST_IDLE;
              busy_o <= 1'b0;
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
      endcase

      // The engine samples configuration live, so it moves only when a new job is popped.
      if (pop_en) begin
        out_start_addr_o <= head_addr;
        out_datasize_o   <= head_ds;
        out_mode_o       <= head_mode;
        out_len0_o       <= head_len0;
        out_len1_o       <= head_len1;
        out_len2_o       <= head_len2;
      end
    end
  end

endmodule
